// File: rtl/stopwatch_btn_ctrl.sv
// rtl/stopwatch_btn_ctrl.sv - start/stop button synchroniser, debouncer and run-level FSM
// Optional long-press clear behaviour is enabled by defining LONG_PRESS_CLR_EN.

module stopwatch_btn_ctrl #(
    parameter int DEBOUNCE_CNT   = 500000,
    parameter int CNT_W          = 20,
    parameter int LONG_PRESS_CNT = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic start_stop,
    output logic press_pulse,
    output logic clr
);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    state_t           state;
    state_t           state_next;
    logic             s1;
    logic             s2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] db_cnt;
    logic             rise;
    logic             toggle;

    // Plain two-flop synchroniser for the asynchronous board input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // Any cycle of agreement with the accepted level restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (s2 == stable) begin
            db_cnt <= '0;
        end else if (db_cnt >= DB_LAST) begin
            stable <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d    <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            stable_d    <= stable;
            press_pulse <= rise;
        end
    end

    assign rise = stable & ~stable_d;

`ifdef LONG_PRESS_CLR_EN
    localparam int              HOLD_W    = $clog2(LONG_PRESS_CNT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CNT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CNT - 1);

    logic              fall;
    logic [HOLD_W-1:0] hold_cnt;

    assign fall = ~stable & stable_d;

    // Hold length saturates so a very long hold cannot wrap into a short one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            clr      <= 1'b0;
        end else begin
            clr <= stable && (state == STOPPED) && (hold_cnt == HOLD_LAST);
            if (fall) begin
                hold_cnt <= '0;
            end else if (stable && (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    // A long press while stopped was a clear request, so its release is swallowed
    assign toggle = fall && ((hold_cnt < HOLD_MAX) || (state == RUNNING));
`else
    assign clr    = 1'b0;
    assign toggle = press_pulse;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STOPPED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (toggle) begin
            case (state)
                STOPPED: state_next = RUNNING;
                RUNNING: state_next = STOPPED;
                default: state_next = STOPPED;
            endcase
        end
    end

    assign start_stop = (state == RUNNING);

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// tb/tb_stopwatch_btn_ctrl.sv - directed self-checking bench for stopwatch_btn_ctrl

module tb_stopwatch_btn_ctrl;

    localparam int DB = 4;
    localparam int CW = 8;
    localparam int LP = 20;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic start_stop;
    logic press_pulse;
    logic clr;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulses;
    int first_pulse;
    int clrs;
    int first_clr;
    int all_clrs     = 0;
    int acc;

    always #5 clk = ~clk;

    stopwatch_btn_ctrl #(
        .DEBOUNCE_CNT  (DB),
        .CNT_W         (CW),
        .LONG_PRESS_CNT(LP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .start_stop (start_stop),
        .press_pulse(press_pulse),
        .clr        (clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, recording pulse counts and 1-based cycle of first pulse
    task automatic run(input int n);
        pulses      = 0;
        first_pulse = 0;
        clrs        = 0;
        first_clr   = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (press_pulse === 1'b1) begin
                pulses++;
                if (first_pulse == 0) first_pulse = i;
            end
            if (clr === 1'b1) begin
                clrs++;
                all_clrs++;
                if (first_clr == 0) first_clr = i;
            end
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        btn_in = 1'b0;
        tick();
        tick();
        check("rst_start_stop", start_stop, 0);
        check("rst_press_pulse", press_pulse, 0);
        check("rst_clr", clr, 0);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

`ifdef LONG_PRESS_CLR_EN
        btn_in = 1'b1;
        run(5);
        acc = pulses;
        btn_in = 1'b0;
        run(20);
        check("short_pulses", acc + pulses, 1);
        check("short_release_run", start_stop, 1);
        check("short_no_clr", clrs, 0);

        btn_in = 1'b1;
        run(30);
        check("run_long_pulses", pulses, 1);
        check("run_long_no_clr", clrs, 0);
        check("run_long_held_ss", start_stop, 1);
        btn_in = 1'b0;
        run(20);
        check("run_long_release_ss", start_stop, 0);
        check("run_long_release_clr", clrs, 0);

        btn_in = 1'b1;
        run(30);
        check("stop_long_clr_cnt", clrs, 1);
        check("stop_long_clr_cycle", first_clr, 26);
        check("stop_long_held_ss", start_stop, 0);
        btn_in = 1'b0;
        run(20);
        check("stop_long_release_ss", start_stop, 0);
        check("stop_long_release_clr", clrs, 0);
`else
        // Clean press: pulse 7 cycles after the edge, run level one edge later
        btn_in = 1'b1;
        run(7);
        check("t1_first_pulse", first_pulse, 7);
        check("t1_pulses", pulses, 1);
        check("t1_ss_during_pulse", start_stop, 0);
        tick();
        check("t1_pulse_low", press_pulse, 0);
        check("t1_ss_running", start_stop, 1);

        btn_in = 1'b0;
        run(12);
        check("t2_release_pulses", pulses, 0);
        check("t2_release_ss", start_stop, 1);

        btn_in = 1'b1; run(2); acc = pulses;
        btn_in = 1'b0; run(2); acc += pulses;
        btn_in = 1'b1; run(2); acc += pulses;
        btn_in = 1'b0; run(2); acc += pulses;
        check("t2_bounce_pulses", acc, 0);
        check("t2_bounce_ss", start_stop, 1);
        btn_in = 1'b1;
        run(10);
        check("t2_first_pulse", first_pulse, 7);
        check("t2_pulses", pulses, 1);
        check("t2_ss_stopped", start_stop, 0);

        btn_in = 1'b0; run(12);
        btn_in = 1'b1; run(12);
        check("t3_press1_ss", start_stop, 1);
        btn_in = 1'b0; run(12);
        btn_in = 1'b1; run(12);
        check("t3_press2_ss", start_stop, 0);
        btn_in = 1'b0; run(12);
        btn_in = 1'b1;
        run(1000);
        check("t3_hold_pulses", pulses, 1);
        check("t3_hold_ss", start_stop, 1);

        // 3-cycle glitch is rejected, 4-cycle press is just accepted
        btn_in = 1'b0; run(12);
        btn_in = 1'b1; run(3); acc = pulses;
        btn_in = 1'b0; run(12); acc += pulses;
        check("glitch3_pulses", acc, 0);
        check("glitch3_ss", start_stop, 1);
        btn_in = 1'b1; run(4); acc = pulses;
        btn_in = 1'b0; run(12);
        check("press4_pulses", acc + pulses, 1);
        check("press4_first_pulse", first_pulse, 3);
        check("press4_ss", start_stop, 0);

        btn_in = 1'b1; run(12);
        check("t4_pre_ss", start_stop, 1);
        btn_in = 1'b0; run(12);
        btn_in = 1'b1;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("t4_async_ss", start_stop, 0);
        check("t4_async_pp", press_pulse, 0);
        check("t4_async_clr", clr, 0);
        tick();
        tick();
        rst = 1'b0;
        run(10);
        check("t4_first_pulse", first_pulse, 7);
        check("t4_pulses", pulses, 1);
        check("t4_ss", start_stop, 1);

        check("no_clr_ever", all_clrs, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
